// File: rtl/sync_pkg.sv
// Shared helpers for the input conditioner: constant clog2 and parameter
// bound checks used at elaboration.
package sync_pkg;

    localparam int unsigned MIN_SYNC   = 2;
    localparam int unsigned MIN_FILTER = 1;

    // Smallest r with 2**r >= v; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // True when the synchronizer depth and filter length are legal.
    function automatic bit params_ok(input int unsigned num_sync,
                                     input int unsigned filter_len);
        return (num_sync >= MIN_SYNC) && (filter_len >= MIN_FILTER);
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One conditioner channel: synchronizer chain, stability filter, edge pulses.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   ena        filter sample strobe
//   d          asynchronous input
//   q          filtered level (reset RST_BIT)
//   rise, fall registered one-cycle pulses coincident with q changes
//   upd_c      combinational next-state pulse (q updates on this edge)
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int unsigned NUM_SYNC   = 3,
    parameter int unsigned FILTER_LEN = 4,
    parameter bit          RST_BIT    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic upd_c
);

    localparam int unsigned    CW   = clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(FILTER_LEN - 1);

    logic [NUM_SYNC-1:0] s;
    logic [CW-1:0]       cnt;
    logic                s_out;
    logic                differ_c;
    logic                accept_c;

    // Only s[0] may go metastable; later stages see settled values.
    assign s_out    = s[NUM_SYNC-1];
    assign differ_c = (s_out != q);
    assign accept_c = differ_c && ena && (cnt == LAST);
    assign upd_c    = accept_c;

    // Synchronizer runs every cycle; the filter advances only on strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= {NUM_SYNC{RST_BIT}};
            cnt  <= '0;
            q    <= RST_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s    <= {s[NUM_SYNC-2:0], d};
            rise <= accept_c && s_out;
            fall <= accept_c && !s_out;
            if (!differ_c) begin
                // Any agreeing sample restarts the qualification run.
                cnt <= '0;
            end else if (accept_c) begin
                q   <= s_out;
                cnt <= '0;
            end else if (ena) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: per-channel synchronize, filter and
// edge-detect, plus a registered "any channel changed" flag.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   ena        filter sample strobe shared by all channels
//   d          asynchronous channel inputs
//   q          filtered levels (reset RST_STATE)
//   rise, fall one-cycle edge pulses per channel
//   changed    OR of all rise|fall, aligned with the pulses
module sync_debounce
    import sync_pkg::*;
#(
    parameter int unsigned              NUM_CH     = 1,
    parameter int unsigned              NUM_SYNC   = 3,
    parameter int unsigned              FILTER_LEN = 4,
    parameter logic [NUM_CH-1:0]        RST_STATE  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NUM_CH-1:0] d,
    output logic [NUM_CH-1:0] q,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              changed
);

    if (!params_ok(NUM_SYNC, FILTER_LEN)) begin : g_bad_params
        $error("sync_debounce: NUM_SYNC must be >= 2 and FILTER_LEN >= 1");
    end

    logic [NUM_CH-1:0] upd_c;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_debounce_ch #(
            .NUM_SYNC   (NUM_SYNC),
            .FILTER_LEN (FILTER_LEN),
            .RST_BIT    (RST_STATE[i])
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .ena   (ena),
            .d     (d[i]),
            .q     (q[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .upd_c (upd_c[i])
        );
    end

    // Registered from next-state pulses so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= |upd_c;
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce (4 channels, NUM_SYNC=3, FILTER_LEN=4,
// RST_STATE=4'b0101). Stimulus pushes expected {edge, q, rise, fall}; the
// monitor pops one entry each time changed is seen.
module tb_sync_debounce;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    typedef struct {
        int         cyc;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   ena_mode = 0;
    int   strobe_skip = -1;

    sync_debounce #(
        .NUM_CH     (4),
        .NUM_SYNC   (3),
        .FILTER_LEN (4),
        .RST_STATE  (4'b0101)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .d       (d),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: every changed cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (changed) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_changed edge=%0d q=%b rise=%b fall=%b", edge_n, q, rise, fall);
            end else begin
                e = sb.pop_front();
                if (edge_n != e.cyc || q != e.q || rise != e.rise || fall != e.fall) begin
                    errors++;
                    $display("FAIL update got edge=%0d q=%b rise=%b fall=%b, want edge=%0d q=%b rise=%b fall=%b",
                             edge_n, q, rise, fall, e.cyc, e.q, e.rise, e.fall);
                end
            end
        end else begin
            checks++;
            if (rise != 4'b0000 || fall != 4'b0000) begin
                errors++;
                $display("FAIL pulse_without_changed edge=%0d rise=%b fall=%b want 0000", edge_n, rise, fall);
            end
        end
    end

    // Advance to the next negedge and set ena for the following edge.
    task automatic tick();
        @(negedge clk);
        if (ena_mode == 0) ena = 1'b1;
        else ena = (((edge_n + 1) % 4) == 0) && ((edge_n + 1) != strobe_skip);
    endtask

    task automatic check_idle(input string name, input logic [3:0] want_q);
        checks++;
        if (q != want_q || rise != 4'b0000 || fall != 4'b0000 || changed != 1'b0) begin
            errors++;
            $display("FAIL %s got q=%b rise=%b fall=%b changed=%b, want q=%b rise=0000 fall=0000 changed=0",
                     name, q, rise, fall, changed, want_q);
        end
    endtask

    task automatic expect_upd(input int cyc, input logic [3:0] eq,
                              input logic [3:0] er, input logic [3:0] ef);
        exp_t e;
        e.cyc = cyc; e.q = eq; e.rise = er; e.fall = ef;
        sb.push_back(e);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        ena = 1'b1;
        d   = 4'b0101;

        // Reset state held and after release with d == RST_STATE.
        repeat (3) tick();
        check_idle("reset_hold", 4'b0101);
        rst = 1'b0;
        repeat (10) tick();
        check_idle("after_release", 4'b0101);

        // ch1 rise, ena=1: E0 = k+1, update at E6 = k+7.
        k = edge_n;
        d = 4'b0111;
        expect_upd(k + 7, 4'b0111, 4'b0010, 4'b0000);
        repeat (4) tick();
        check_idle("no_early_rise", 4'b0101);
        repeat (8) tick();

        // ch3 bounce: high 3, low 1, high; only the final run qualifies.
        k = edge_n;
        d[3] = 1'b1;
        repeat (3) tick();
        d[3] = 1'b0;
        tick();
        d[3] = 1'b1;
        expect_upd(k + 11, 4'b1111, 4'b1000, 4'b0000);
        repeat (4) tick();
        check_idle("bounce_no_early", 4'b0111);
        repeat (10) tick();

        // ch0 fall with ena every 4th edge; the strobe at k+9 is suppressed,
        // so strobes k+5, k+13, k+17, k+21 qualify.
        ena_mode = 1;
        while ((edge_n % 4) != 3) tick();
        k = edge_n;
        strobe_skip = k + 9;
        d[0] = 1'b0;
        expect_upd(k + 21, 4'b1110, 4'b0000, 4'b0001);
        repeat (18) tick();
        check_idle("strobe_no_early", 4'b1111);
        repeat (8) tick();
        ena_mode = 0;
        strobe_skip = -1;
        tick();

        // Reset with ch2 cnt=2: no pulse, q back to RST_STATE.
        k = edge_n;
        d[2] = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_idle("reset_mid_count", 4'b0101);
        tick();
        rst = 1'b0;
        // d=1010 differs from RST_STATE on all channels; E0 = k+8.
        expect_upd(k + 14, 4'b1010, 4'b1010, 4'b0101);
        repeat (3) tick();
        check_idle("post_reset_no_early", 4'b0101);
        repeat (10) tick();

        // Simultaneous ch2 rise / ch1 fall, then ch1 rise / ch2 fall.
        k = edge_n;
        d = 4'b1100;
        expect_upd(k + 7, 4'b1100, 4'b0100, 4'b0010);
        repeat (10) tick();
        k = edge_n;
        d = 4'b1010;
        expect_upd(k + 7, 4'b1010, 4'b0010, 4'b0100);
        repeat (10) tick();
        check_idle("final_level", 4'b1010);

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_updates got %0d pending, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
